// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - front-panel button conditioning and run/set-time controller
module clock_set_ctrl #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int TIMEOUT       = 500000000,
  parameter int BLINK_DIV     = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] swch,
  input  logic       BUT1,
  input  logic       BUT2,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic [1:0] fld_blank
);

  localparam int RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DebW   = $clog2(DEB_CYCLES + 1);
  localparam int RepW   = $clog2(RepMax + 1);
  localparam int IdleW  = $clog2(TIMEOUT + 1);
  localparam int BlinkW = $clog2(BLINK_DIV + 1);

  localparam logic [DebW-1:0]   debLast    = DebW'(DEB_CYCLES - 1);
  localparam logic [RepW-1:0]   delayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0]   periodLast = RepW'(REPEAT_PERIOD - 1);
  localparam logic [IdleW-1:0]  idleLast   = IdleW'(TIMEOUT - 1);
  localparam logic [BlinkW-1:0] blinkLast  = BlinkW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    Run    = 2'b00,
    SetHr  = 2'b01,
    SetMin = 2'b10
  } stateT;

  // Index 0 is BUT1 (field select), index 1 is BUT2 (increment).
  logic [1:0]      btnMeta;
  logic [1:0]      btnSync;
  logic [1:0]      debounced;
  logic [1:0]      pressEvt;
  logic [DebW-1:0] debCnt [2];

  stateT             state;
  stateT             nextState;
  logic              nextIncH;
  logic              nextIncM;
  logic              nextClr;
  logic              nextPhase;
  logic              stateChange;
  logic              inSet;
  logic              anyHeld;
  logic              idleExpire;
  logic              repFire;
  logic [IdleW-1:0]  idleCnt;
  logic [RepW-1:0]   repCnt;
  logic              repActive;
  logic              repArmed;
  logic [BlinkW-1:0] blinkCnt;
  logic              phase;

  // Synchronize the raw buttons and accept a new level only after it has held for DEB_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnMeta   <= 2'b11;
      btnSync   <= 2'b11;
      debounced <= 2'b00;
      pressEvt  <= 2'b00;
      debCnt[0] <= '0;
      debCnt[1] <= '0;
    end else begin
      btnMeta <= {BUT2, BUT1};
      btnSync <= btnMeta;
      for (int i = 0; i < 2; i++) begin
        pressEvt[i] <= 1'b0;
        if (~btnSync[i] != debounced[i]) begin
          if (debCnt[i] == debLast) begin
            debCnt[i]    <= '0;
            debounced[i] <= ~debounced[i];
            pressEvt[i]  <= ~debounced[i];
          end else begin
            debCnt[i] <= debCnt[i] + 1'b1;
          end
        end else begin
          debCnt[i] <= '0;
        end
      end
    end
  end

  assign inSet       = (state != Run);
  assign anyHeld     = |debounced;
  assign idleExpire  = inSet && !anyHeld && (idleCnt == idleLast);
  assign repFire     = repActive && debounced[1] && (repCnt == (repArmed ? periodLast : delayLast));
  assign stateChange = (nextState != state);
  assign nextPhase   = stateChange ? 1'b0 : ((blinkCnt == blinkLast) ? ~phase : phase);

  // Next-state and strobe decode; lock/timeout outrank BUT1, which outranks any increment.
  always_comb begin
    nextState = state;
    nextIncH  = 1'b0;
    nextIncM  = 1'b0;
    nextClr   = 1'b0;
    case (state)
      Run: begin
        if (pressEvt[0] && !swch[1]) nextState = SetHr;
      end
      SetHr, SetMin: begin
        if (swch[1] || idleExpire) begin
          nextState = Run;
        end else if (pressEvt[0]) begin
          if (state == SetHr) begin
            nextState = SetMin;
          end else begin
            nextState = Run;
            nextClr   = 1'b1;
          end
        end else if (pressEvt[1] || repFire) begin
          nextIncH = (state == SetHr);
          nextIncM = (state == SetMin);
        end
      end
      default: nextState = Run;
    endcase
  end

  // State register with registered per-state outputs and one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= Run;
      run_en    <= 1'b1;
      inc_hour  <= 1'b0;
      inc_min   <= 1'b0;
      clr_sec   <= 1'b0;
      fld_blank <= 2'b00;
    end else begin
      state     <= nextState;
      run_en    <= (nextState == Run);
      inc_hour  <= nextIncH;
      inc_min   <= nextIncM;
      clr_sec   <= nextClr;
      fld_blank <= {(nextState == SetHr) & nextPhase & swch[0],
                    (nextState == SetMin) & nextPhase & swch[0]};
    end
  end

  assign mode = state;

  // Idle timeout, BUT2 auto-repeat and blink phase counters, all restarted on state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idleCnt   <= '0;
      repCnt    <= '0;
      repActive <= 1'b0;
      repArmed  <= 1'b0;
      blinkCnt  <= '0;
      phase     <= 1'b0;
    end else begin
      phase <= nextPhase;
      if (stateChange || blinkCnt == blinkLast) blinkCnt <= '0;
      else                                      blinkCnt <= blinkCnt + 1'b1;

      if (stateChange || nextState == Run || anyHeld) idleCnt <= '0;
      else                                            idleCnt <= idleCnt + 1'b1;

      // Repeats only follow a real first strobe; the first gap is REPEAT_DELAY, later ones REPEAT_PERIOD.
      if (stateChange || !inSet || !debounced[1]) begin
        repCnt    <= '0;
        repActive <= 1'b0;
        repArmed  <= 1'b0;
      end else if (nextIncH || nextIncM) begin
        repCnt    <= '0;
        repActive <= 1'b1;
        repArmed  <= repActive;
      end else if (repActive) begin
        repCnt <= repCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int TO  = 100;
  localparam int BD  = 8;
  localparam int NS  = 19;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] swch = 2'b01;
  logic       but1 = 1'b1;
  logic       but2 = 1'b1;
  logic       run_en, inc_hour, inc_min, clr_sec;
  logic [1:0] mode, fld_blank;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TO), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .swch(swch), .BUT1(but1), .BUT2(but2),
    .run_en(run_en), .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec),
    .mode(mode), .fld_blank(fld_blank)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time-stamp based, one evaluation per clock edge.
  int         n, mState, mEntry, mIdleSince, mT0;
  logic [1:0] mS0, mS1, mDeb, mEvt, mFld;
  logic [DEB-1:0] mHist [2];
  logic       mRun, mIncH, mIncM, mClr;

  task automatic modelReset();
    n = 0; mState = 0; mEntry = 0; mIdleSince = 0; mT0 = -1;
    mS0 = 2'b11; mS1 = 2'b11; mDeb = 2'b00; mEvt = 2'b00;
    mHist[0] = '0; mHist[1] = '0;
    mRun = 1'b1; mIncH = 1'b0; mIncM = 1'b0; mClr = 1'b0; mFld = 2'b00;
  endtask

  task automatic modelEdge();
    int nxt, d;
    bit incH, incM, clr, busy, expire, rep, ph;
    logic [1:0] lvl;
    n++;
    busy = mDeb[0] | mDeb[1];
    if (!mDeb[1]) mT0 = -1;
    expire = (mState != 0) && !busy && (n - mIdleSince == TO);
    if (busy) mIdleSince = n;
    d = n - mT0;
    rep = (mT0 >= 0) && (d == RD || (d > RD && (d - RD) % RP == 0));
    nxt = mState; incH = 0; incM = 0; clr = 0;
    if (mState == 0) begin
      if (mEvt[0] && !swch[1]) nxt = 1;
    end else if (swch[1] || expire) begin
      nxt = 0;
    end else if (mEvt[0]) begin
      nxt = (mState == 1) ? 2 : 0;
      clr = (mState == 2);
    end else if (mEvt[1] || rep) begin
      incH = (mState == 1);
      incM = (mState == 2);
      if (mEvt[1]) mT0 = n;
    end
    if (nxt != mState) begin
      mEntry = n; mIdleSince = n; mT0 = -1;
    end
    if (nxt == 0) mT0 = -1;
    mState = nxt;
    ph = (((n - mEntry) / BD) % 2) == 1;
    mRun = (nxt == 0); mIncH = incH; mIncM = incM; mClr = clr;
    mFld = {(nxt == 1) && ph && swch[0], (nxt == 2) && ph && swch[0]};
    lvl = ~mS1;
    mS1 = mS0;
    mS0 = {but2, but1};
    mEvt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mHist[i] = {mHist[i][DEB-2:0], lvl[i]};
      if (mHist[i] == {DEB{~mDeb[i]}}) begin
        mDeb[i] = ~mDeb[i];
        mEvt[i] = mDeb[i];
      end
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelEdge();
    end
  end

  // Lockstep comparison of every output against the model, every cycle out of reset.
  initial begin
    logic [7:0] actV, expV;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        actV = {run_en, inc_hour, inc_min, clr_sec, mode, fld_blank};
        expV = {mRun, mIncH, mIncM, mClr, 2'(mState), mFld};
        tests++;
        if (actV !== expV) begin
          fails++;
          $display("FAIL model_lockstep t=%0t {run,incH,incM,clr,mode,fld}: got %b, expected %b",
                   $time, actV, expV);
        end
      end
    end
  end

  typedef struct {
    logic       b1;
    logic       b2;
    logic [1:0] sw;
    int         cyc;
    int         eMode;
    int         eRun;
    int         nH;
    int         nM;
    int         nC;
  } stepT;

  stepT tbl [NS];
  int   lat, t, el, cH, cM, cC, badMin;
  int   offs[$];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 2'b01,  3, 0, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 12, 1, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 2'b01, 12, 1, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 12, 1, 0, 1, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 2'b01, 12, 1, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 2'b01, 12, 2, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 2'b01, 12, 2, 0, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 2'b01, 12, 2, 0, 0, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 2'b01, 12, 2, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 2'b01, 12, 0, 1, 0, 0, 1};
    tbl[10] = '{1'b1, 1'b1, 2'b01, 12, 0, 1, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 2'b11, 12, 0, 1, 0, 0, 0};
    tbl[12] = '{1'b1, 1'b1, 2'b11, 12, 0, 1, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 12, 1, 0, 0, 0, 0};
    tbl[14] = '{1'b1, 1'b1, 2'b01, 12, 1, 0, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b0, 2'b01, 12, 2, 0, 0, 0, 0};
    tbl[16] = '{1'b1, 1'b1, 2'b01, 12, 2, 0, 0, 0, 0};
    tbl[17] = '{1'b1, 1'b1, 2'b11,  3, 0, 1, 0, 0, 0};
    tbl[18] = '{1'b1, 1'b1, 2'b01,  3, 0, 1, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_run_en", int'(run_en), 1);
    check("rst_mode", int'(mode), 0);
    check("rst_strobes", int'({inc_hour, inc_min, clr_sec}), 0);
    check("rst_fld_blank", int'(fld_blank), 0);
    rst_n = 1'b1;

    // Short BUT1 glitch is rejected
    but1 = 1'b0;
    repeat (2) @(negedge clk);
    but1 = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_mode", int'(mode), 0);

    // Press latency and blink phase on entry to SET_HR
    but1 = 1'b0;
    lat = 0;
    while (mode != 2'd1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("press_latency_in_window", int'(lat >= DEB + 2 && lat <= DEB + 4), 1);
    check("sethr_run_en", int'(run_en), 0);
    for (int k = 1; k <= 16; k++) begin
      if (k >= 10 - lat) but1 = 1'b1;
      @(negedge clk);
      if (k == 7 || k == 16) check("blink_visible", int'(fld_blank), 0);
      if (k == 8 || k == 15) check("blink_blanked", int'(fld_blank), 2);
    end
    but1 = 1'b1;

    // Auto-repeat timing while BUT2 is held in SET_HR
    but2 = 1'b0;
    t = 0;
    while (!inc_hour && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rep_first_strobe", int'(inc_hour), 1);
    offs.delete();
    offs.push_back(0);
    badMin = 0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 52) but2 = 1'b1;
      @(negedge clk);
      if (inc_hour) offs.push_back(k);
      if (inc_min) badMin++;
    end
    check("rep_pulse_count", offs.size(), 9);
    for (int j = 1; j < offs.size() && j < 9; j++)
      check($sformatf("rep_offset_%0d", j), offs[j], RD + (j - 1) * RP);
    check("rep_no_inc_min", badMin, 0);

    // Raising the lock aborts the edit on the next cycle
    swch = 2'b11;
    @(negedge clk);
    check("lock_abort_mode", int'(mode), 0);
    check("lock_abort_no_clr", int'(clr_sec), 0);

    // Table-driven button sequences
    for (int s = 0; s < NS; s++) begin
      but1 = tbl[s].b1;
      but2 = tbl[s].b2;
      swch = tbl[s].sw;
      cH = 0; cM = 0; cC = 0;
      repeat (tbl[s].cyc) begin
        @(negedge clk);
        cH += int'(inc_hour);
        cM += int'(inc_min);
        cC += int'(clr_sec);
        if (clr_sec) check($sformatf("step%0d_clr_with_run", s), int'(run_en), 1);
      end
      check($sformatf("step%0d_mode", s), int'(mode), tbl[s].eMode);
      check($sformatf("step%0d_run_en", s), int'(run_en), tbl[s].eRun);
      check($sformatf("step%0d_inc_hour_cnt", s), cH, tbl[s].nH);
      check($sformatf("step%0d_inc_min_cnt", s), cM, tbl[s].nM);
      check($sformatf("step%0d_clr_sec_cnt", s), cC, tbl[s].nC);
    end

    // Idle timeout from SET_HR without clr_sec
    but1 = 1'b0;
    t = 0;
    while (mode != 2'd1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("timeout_enter", int'(mode), 1);
    but1 = 1'b1;
    el = 0; cC = 0;
    while (mode != 2'd0 && el < 250) begin
      @(negedge clk);
      el++;
      cC += int'(clr_sec);
    end
    check("timeout_mode", int'(mode), 0);
    check("timeout_window", int'(el >= TO && el <= TO + 12), 1);
    check("timeout_no_clr", cC, 0);

    // Reset in the middle of an edit
    but1 = 1'b0;
    repeat (12) @(negedge clk);
    but1 = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_mode", int'(mode), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_mode", int'(mode), 0);
    check("midreset_run_en", int'(run_en), 1);
    check("midreset_strobes", int'({inc_hour, inc_min, clr_sec}), 0);
    check("midreset_fld", int'(fld_blank), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized button and switch activity checked by the lockstep model
    for (int r = 0; r < 300; r++) begin
      but1 = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      but2 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0)
        swch = {($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    but1 = 1'b1;
    but2 = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
